bus_arbiter4: RTL

- Round-robin arbiter sharing one `datasize`-wide tri-state bus between four requesters.
- Drives the select of the existing four-input mux, so exactly one source drives the bus at a time.
- Inserts one turnaround cycle between owners so two drivers never overlap on the tri-stated bus.
- Enforces a maximum tenure per grant for fairness.

---
 rtl/bus_arbiter4.sv | 121 ++++++++++++
 1 files changed

// File: rtl/bus_arbiter4.sv
// Round-robin arbiter for four requesters sharing one tri-state bus.
// Drives the mux select, inserts a one-cycle turnaround between owners and caps each tenure.
module bus_arbiter4 #(
  parameter int CNTW    = 4,
  parameter int HOLDMAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       bus_en,
  output logic       expired
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_e;

  localparam logic [CNTW-1:0] HOLD_LIM = CNTW'(HOLDMAX);

  state_e          state_q, state_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            exp_q, exp_d;
  logic            bus_en_q;

  logic            win_vld;
  logic [1:0]      win_idx;
  logic [1:0]      cand;
  logic            at_lim;
  logic            owner_req;

  // Walk from ptr+4 down to ptr+1 so the nearest requester after ptr overrides the rest.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    cand    = ptr_q;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr_q + 2'(k);
      if (req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign at_lim    = (cnt_q == HOLD_LIM);
  assign owner_req = req[ptr_q];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    exp_d   = 1'b0;
    case (state_q)
      IDLE, TURN: begin
        if (win_vld) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win_idx;
          sel_d   = win_idx;
          ptr_d   = win_idx;
          cnt_d   = CNTW'(1);
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
        end
      end
      GRANT: begin
        if (done || !owner_req || at_lim) begin
          state_d = TURN;
          gnt_d   = 4'b0000;
          // Flag only releases forced purely by the tenure cap.
          exp_d   = at_lim && !done && owner_req;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= 4'b0000;
      sel_q    <= 2'd0;
      ptr_q    <= 2'd3;
      cnt_q    <= '0;
      exp_q    <= 1'b0;
      bus_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      bus_en_q <= |gnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign bus_en  = bus_en_q;
  assign expired = exp_q;

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_bus_en: assert property (@(posedge clk) disable iff (rst) bus_en == (|gnt));
  a_gap:    assert property (@(posedge clk) disable iff (rst)
                             (gnt != 4'b0000 && $past(gnt) != 4'b0000) |-> gnt == $past(gnt));
  a_sel:    assert property (@(posedge clk) disable iff (rst)
                             (bus_en && $past(bus_en)) |-> sel == $past(sel));

endmodule
